// File: rtl/branch_check_queue_pkg.sv
// ----------------------------------------------------------------------------
// branch_check_queue_pkg
//   Shared definitions for the branch check queue.
//   - BCQ_DELAY_SLOT_OFF : not-taken fall-through distance (branch + delay slot)
//   - entry layout helpers for the packed {pc, taken, addr} queue word
//   - res_kind_t         : classification of a resolution against the queue head
// ----------------------------------------------------------------------------
package branch_check_queue_pkg;

  localparam int unsigned BCQ_DELAY_SLOT_OFF = 32'd8;

  // Resolution outcome for the current cycle.
  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_MATCH   = 2'd1,
    RES_MISPRED = 2'd2,
    RES_EMPTY   = 2'd3
  } res_kind_t;

  // Packed entry word: [2*A : A+1] = pc, [A] = taken, [A-1 : 0] = addr.
  function automatic int unsigned bcq_entry_w(input int unsigned addr_w);
    return (2 * addr_w) + 1;
  endfunction

  function automatic int unsigned bcq_addr_off(input int unsigned addr_w);
    return addr_w - addr_w;
  endfunction

  function automatic int unsigned bcq_taken_off(input int unsigned addr_w);
    return addr_w;
  endfunction

  function automatic int unsigned bcq_pc_off(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/branch_check_queue_fifo.sv
// ----------------------------------------------------------------------------
// branch_check_queue_fifo
//   DEPTH x WIDTH register FIFO holding in-flight branch predictions.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     push       : write wdata at the tail (caller guarantees space or pop)
//     pop        : advance the head (caller guarantees non-empty)
//     clear      : flush all entries; overrides push and pop
//     wdata      : entry to write
//     rdata      : current head entry
//     full/empty : occupancy status
// ----------------------------------------------------------------------------
module branch_check_queue_fifo
  import branch_check_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointer and occupancy state; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W + 1)'(1);
      end else begin
        count <= count;
      end
    end
  end

  // Entry storage; contents are only observed while the slot is occupied,
  // so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/branch_check_queue.sv
// ----------------------------------------------------------------------------
// branch_check_queue
//   Holds each fetch-time prediction until its branch resolves in MEM, checks
//   the resolution against it and, on a mismatch, raises a one-cycle Flush with
//   the correct Redirect_addr. A mispredict discards every queued (wrong-path)
//   entry.
//   Ports:
//     CLK, RESET        : clock, asynchronous active-low reset
//     Pred_*            : prediction push from fetch {pc, taken, addr}
//     Res_*             : branch resolution from MEM {pc, taken, addr}
//     Full, Empty       : queue occupancy
//     Flush             : registered one-cycle mispredict pulse
//     Redirect_addr     : correct next PC, valid while Flush=1
//     Order_error       : sticky protocol/ordering error
//     Branch_count      : resolved branches (saturating)
//     Mispredict_count  : mispredicted branches (saturating)
// ----------------------------------------------------------------------------
module branch_check_queue
  import branch_check_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Pred_valid,
  input  logic [ADDR_W-1:0] Pred_pc,
  input  logic              Pred_taken,
  input  logic [ADDR_W-1:0] Pred_addr,
  input  logic              Res_valid,
  input  logic [ADDR_W-1:0] Res_pc,
  input  logic              Res_taken,
  input  logic [ADDR_W-1:0] Res_addr,
  output logic              Full,
  output logic              Empty,
  output logic              Flush,
  output logic [ADDR_W-1:0] Redirect_addr,
  output logic              Order_error,
  output logic [CNT_W-1:0]  Branch_count,
  output logic [CNT_W-1:0]  Mispredict_count
);

  localparam int ENTRY_W   = int'(bcq_entry_w(ADDR_W));
  localparam int ADDR_OFF  = int'(bcq_addr_off(ADDR_W));
  localparam int TAKEN_OFF = int'(bcq_taken_off(ADDR_W));
  localparam int PC_OFF    = int'(bcq_pc_off(ADDR_W));

  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [ADDR_W-1:0]  head_pc;
  logic               head_taken;
  logic [ADDR_W-1:0]  head_addr;

  logic               fifo_full;
  logic               fifo_empty;

  res_kind_t          res_kind;
  logic               pc_mismatch;
  logic               dir_mismatch;
  logic               addr_mismatch;
  logic               pop;
  logic               mispredict;
  logic               res_on_empty;
  logic               push;
  logic               push_dropped;
  logic [ADDR_W-1:0]  target;

  assign wr_entry   = {Pred_pc, Pred_taken, Pred_addr};
  assign head_pc    = head_entry[PC_OFF +: ADDR_W];
  assign head_taken = head_entry[TAKEN_OFF];
  assign head_addr  = head_entry[ADDR_OFF +: ADDR_W];

  branch_check_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (push),
    .pop   (pop),
    .clear (mispredict),
    .wdata (wr_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Classify the resolution against the head. The target is only compared on
  // a taken resolution; a not-taken prediction's addr is don't-care.
  always_comb begin
    pc_mismatch   = (Res_pc != head_pc);
    dir_mismatch  = (Res_taken != head_taken);
    addr_mismatch = Res_taken && (Res_addr != head_addr);
    if (!Res_valid) begin
      res_kind = RES_NONE;
    end else if (fifo_empty) begin
      res_kind = RES_EMPTY;
    end else if (pc_mismatch || dir_mismatch || addr_mismatch) begin
      res_kind = RES_MISPRED;
    end else begin
      res_kind = RES_MATCH;
    end
  end

  // Decode the resolution kind into queue actions.
  always_comb begin
    pop          = 1'b0;
    mispredict   = 1'b0;
    res_on_empty = 1'b0;
    case (res_kind)
      RES_MATCH: begin
        pop = 1'b1;
      end
      RES_MISPRED: begin
        pop        = 1'b1;
        mispredict = 1'b1;
      end
      RES_EMPTY: begin
        res_on_empty = 1'b1;
      end
      default: begin
        pop = 1'b0;
      end
    endcase
  end

  // Push gating: a pop frees a slot the same cycle; a mispredict discards the
  // push because it belongs to the wrong path.
  always_comb begin
    push_dropped = Pred_valid && fifo_full && !pop;
    if (Pred_valid && (!fifo_full || pop) && !mispredict) begin
      push = 1'b1;
    end else begin
      push = 1'b0;
    end
  end

  // Correct next PC: taken -> resolved target, not taken -> fall through past
  // the delay slot (wraps modulo 2^ADDR_W).
  always_comb begin
    if (Res_taken) begin
      target = Res_addr;
    end else begin
      target = Res_pc + ADDR_W'(BCQ_DELAY_SLOT_OFF);
    end
  end

  // Flush pulse and redirect target, registered one cycle after resolution.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Flush         <= 1'b0;
      Redirect_addr <= '0;
    end else begin
      Flush <= mispredict;
      if (mispredict) begin
        Redirect_addr <= target;
      end
    end
  end

  // Sticky ordering error: resolve on empty, PC out of order, or overflow push.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Order_error <= 1'b0;
    end else if (res_on_empty || (pop && pc_mismatch) || push_dropped) begin
      Order_error <= 1'b1;
    end
  end

  // Saturating statistics counters, updated on every pop.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Branch_count     <= '0;
      Mispredict_count <= '0;
    end else begin
      if (pop && (Branch_count != '1)) begin
        Branch_count <= Branch_count + CNT_W'(1);
      end
      if (mispredict && (Mispredict_count != '1)) begin
        Mispredict_count <= Mispredict_count + CNT_W'(1);
      end
    end
  end

  assign Full  = fifo_full;
  assign Empty = fifo_empty;

endmodule

// File: tb/tb_branch_check_queue.sv
module tb_branch_check_queue;

  logic        CLK;
  logic        RESET;
  logic        Pred_valid;
  logic [31:0] Pred_pc;
  logic        Pred_taken;
  logic [31:0] Pred_addr;
  logic        Res_valid;
  logic [31:0] Res_pc;
  logic        Res_taken;
  logic [31:0] Res_addr;
  logic        Full;
  logic        Empty;
  logic        Flush;
  logic [31:0] Redirect_addr;
  logic        Order_error;
  logic [15:0] Branch_count;
  logic [15:0] Mispredict_count;

  int checks   = 0;
  int failures = 0;

  branch_check_queue dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .Pred_valid       (Pred_valid),
    .Pred_pc          (Pred_pc),
    .Pred_taken       (Pred_taken),
    .Pred_addr        (Pred_addr),
    .Res_valid        (Res_valid),
    .Res_pc           (Res_pc),
    .Res_taken        (Res_taken),
    .Res_addr         (Res_addr),
    .Full             (Full),
    .Empty            (Empty),
    .Flush            (Flush),
    .Redirect_addr    (Redirect_addr),
    .Order_error      (Order_error),
    .Branch_count     (Branch_count),
    .Mispredict_count (Mispredict_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // one clock edge; inputs change and outputs are sampled 1ns after it
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    Pred_valid = 1'b0; Pred_pc = 32'h0; Pred_taken = 1'b0; Pred_addr = 32'h0;
    Res_valid  = 1'b0; Res_pc  = 32'h0; Res_taken  = 1'b0; Res_addr  = 32'h0;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] ad);
    Pred_valid = 1'b1; Pred_pc = pc; Pred_taken = tk; Pred_addr = ad;
    cyc();
    Pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] ad);
    Res_valid = 1'b1; Res_pc = pc; Res_taken = tk; Res_addr = ad;
    cyc();
    Res_valid = 1'b0;
  endtask

  task automatic push_resolve(input logic [31:0] ppc, input logic ptk, input logic [31:0] pad,
                              input logic [31:0] rpc, input logic rtk, input logic [31:0] rad);
    Pred_valid = 1'b1; Pred_pc = ppc; Pred_taken = ptk; Pred_addr = pad;
    Res_valid  = 1'b1; Res_pc  = rpc; Res_taken  = rtk; Res_addr  = rad;
    cyc();
    Pred_valid = 1'b0;
    Res_valid  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    cyc();
  endtask

  task automatic test_initial_reset();
    checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL init_empty got=%b want=1", Empty); end
    checks++; if (Full !== 1'b0) begin failures++; $display("FAIL init_full got=%b want=0", Full); end
    checks++; if (Flush !== 1'b0) begin failures++; $display("FAIL init_flush got=%b want=0", Flush); end
    checks++; if (Branch_count !== 16'd0) begin failures++; $display("FAIL init_bcnt got=%0d want=0", Branch_count); end
  endtask

  task automatic test_match();
    push(32'h100, 1'b1, 32'h200);
    checks++; if (Empty !== 1'b0) begin failures++; $display("FAIL match_not_empty got=%b want=0", Empty); end
    resolve(32'h100, 1'b1, 32'h200);
    checks++; if (Flush !== 1'b0) begin failures++; $display("FAIL match_flush got=%b want=0", Flush); end
    checks++; if (Branch_count !== 16'd1) begin failures++; $display("FAIL match_bcnt got=%0d want=1", Branch_count); end
    checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL match_empty got=%b want=1", Empty); end
    checks++; if (Mispredict_count !== 16'd0) begin failures++; $display("FAIL match_mcnt got=%0d want=0", Mispredict_count); end
  endtask

  task automatic test_mispredict_taken();
    push(32'h100, 1'b0, 32'h0);
    push(32'h120, 1'b1, 32'h300);
    resolve(32'h100, 1'b1, 32'h180);
    checks++; if (Flush !== 1'b1) begin failures++; $display("FAIL mp_flush got=%b want=1", Flush); end
    checks++; if (Redirect_addr !== 32'h180) begin failures++; $display("FAIL mp_redirect got=%h want=00000180", Redirect_addr); end
    checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL mp_empty got=%b want=1", Empty); end
    checks++; if (Mispredict_count !== 16'd1) begin failures++; $display("FAIL mp_mcnt got=%0d want=1", Mispredict_count); end
    checks++; if (Branch_count !== 16'd2) begin failures++; $display("FAIL mp_bcnt got=%0d want=2", Branch_count); end
    cyc();
    checks++; if (Flush !== 1'b0) begin failures++; $display("FAIL mp_flush_pulse got=%b want=0", Flush); end
  endtask

  task automatic test_not_taken_redirect();
    push(32'h100, 1'b1, 32'h200);
    resolve(32'h100, 1'b0, 32'h0);
    checks++; if (Flush !== 1'b1) begin failures++; $display("FAIL nt_flush got=%b want=1", Flush); end
    checks++; if (Redirect_addr !== 32'h108) begin failures++; $display("FAIL nt_redirect got=%h want=00000108", Redirect_addr); end
    push(32'hFFFF_FFFC, 1'b1, 32'h200);
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
    checks++; if (Redirect_addr !== 32'h4) begin failures++; $display("FAIL nt_wrap_redirect got=%h want=00000004", Redirect_addr); end
    checks++; if (Mispredict_count !== 16'd3) begin failures++; $display("FAIL nt_mcnt got=%0d want=3", Mispredict_count); end
    checks++; if (Branch_count !== 16'd4) begin failures++; $display("FAIL nt_bcnt got=%0d want=4", Branch_count); end
    checks++; if (Order_error !== 1'b0) begin failures++; $display("FAIL nt_order got=%b want=0", Order_error); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      push(32'h200 + 32'(i) * 32'h10, 1'b1, 32'h240 + 32'(i) * 32'h10);
    end
    checks++; if (Full !== 1'b1) begin failures++; $display("FAIL full_set got=%b want=1", Full); end
    push_resolve(32'h240, 1'b1, 32'h280, 32'h200, 1'b1, 32'h240);
    checks++; if (Full !== 1'b1) begin failures++; $display("FAIL full_pushpop got=%b want=1", Full); end
    checks++; if (Flush !== 1'b0) begin failures++; $display("FAIL full_pushpop_flush got=%b want=0", Flush); end
    checks++; if (Branch_count !== 16'd5) begin failures++; $display("FAIL full_bcnt got=%0d want=5", Branch_count); end
    resolve(32'h210, 1'b1, 32'h250);
    checks++; if (Flush !== 1'b0) begin failures++; $display("FAIL full_head_adv got=%b want=0", Flush); end
    checks++; if (Full !== 1'b0) begin failures++; $display("FAIL full_clear got=%b want=0", Full); end
    push(32'h250, 1'b1, 32'h290);
    checks++; if (Order_error !== 1'b0) begin failures++; $display("FAIL full_order_pre got=%b want=0", Order_error); end
    push(32'h260, 1'b1, 32'h2A0);
    checks++; if (Order_error !== 1'b1) begin failures++; $display("FAIL full_drop_order got=%b want=1", Order_error); end
    checks++; if (Full !== 1'b1) begin failures++; $display("FAIL full_drop_full got=%b want=1", Full); end
    for (int i = 0; i < 4; i++) begin
      resolve(32'h220 + 32'(i) * 32'h10, 1'b1, 32'h260 + 32'(i) * 32'h10);
      checks++; if (Flush !== 1'b0) begin failures++; $display("FAIL full_drain_%0d got=%b want=0", i, Flush); end
    end
    checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL full_drain_empty got=%b want=1", Empty); end
    checks++; if (Branch_count !== 16'd10) begin failures++; $display("FAIL full_drain_bcnt got=%0d want=10", Branch_count); end
    checks++; if (Mispredict_count !== 16'd3) begin failures++; $display("FAIL full_drain_mcnt got=%0d want=3", Mispredict_count); end
  endtask

  task automatic test_order_errors();
    do_reset();
    resolve(32'h100, 1'b1, 32'h200);
    checks++; if (Flush !== 1'b0) begin failures++; $display("FAIL oe_empty_flush got=%b want=0", Flush); end
    checks++; if (Order_error !== 1'b1) begin failures++; $display("FAIL oe_empty_order got=%b want=1", Order_error); end
    checks++; if (Branch_count !== 16'd0) begin failures++; $display("FAIL oe_empty_bcnt got=%0d want=0", Branch_count); end
    do_reset();
    checks++; if (Order_error !== 1'b0) begin failures++; $display("FAIL oe_reset_clear got=%b want=0", Order_error); end
    push(32'h100, 1'b1, 32'h200);
    resolve(32'h140, 1'b1, 32'h200);
    checks++; if (Flush !== 1'b1) begin failures++; $display("FAIL oe_pc_flush got=%b want=1", Flush); end
    checks++; if (Order_error !== 1'b1) begin failures++; $display("FAIL oe_pc_order got=%b want=1", Order_error); end
    checks++; if (Redirect_addr !== 32'h200) begin failures++; $display("FAIL oe_pc_redirect got=%h want=00000200", Redirect_addr); end
    checks++; if (Mispredict_count !== 16'd1) begin failures++; $display("FAIL oe_pc_mcnt got=%0d want=1", Mispredict_count); end
  endtask

  task automatic test_reset();
    push(32'h500, 1'b1, 32'h600);
    push(32'h510, 1'b0, 32'h0);
    checks++; if (Empty !== 1'b0) begin failures++; $display("FAIL rst_pre_empty got=%b want=0", Empty); end
    #2;
    RESET = 1'b0;
    #1;
    checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b want=1", Empty); end
    checks++; if (Full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b want=0", Full); end
    checks++; if (Flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b want=0", Flush); end
    checks++; if (Redirect_addr !== 32'h0) begin failures++; $display("FAIL rst_redirect got=%h want=00000000", Redirect_addr); end
    checks++; if (Order_error !== 1'b0) begin failures++; $display("FAIL rst_order got=%b want=0", Order_error); end
    checks++; if (Branch_count !== 16'd0) begin failures++; $display("FAIL rst_bcnt got=%0d want=0", Branch_count); end
    checks++; if (Mispredict_count !== 16'd0) begin failures++; $display("FAIL rst_mcnt got=%0d want=0", Mispredict_count); end
    @(negedge CLK);
    RESET = 1'b1;
    cyc();
  endtask

  initial begin
    set_idle();
    RESET = 1'b0;
    #12;
    RESET = 1'b1;
    cyc();
    test_initial_reset();
    test_match();
    test_mispredict_taken();
    test_not_taken_redirect();
    test_full();
    test_order_errors();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
